// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-unit FSM encoding.
// The code constants are also used by consumers of the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  function automatic logic alu_is_mul(logic [3:0] code);
    return code == ALU_MUL;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier returning the low XLEN bits of the product.
// Runs a fixed XLEN steps after start and pulses done for one cycle at the end.
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product_lo
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q  <= multiplicand;
        mplier_q <= multiplier;
        acc_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        // Bits shifted past XLEN are dropped, so only the low half accumulates.
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign product_lo = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete in one cycle; MUL is delegated to shift_add_mul.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;

  logic [XLEN-1:0] alu_out;
  logic            ctrl_bad;
  logic            accept;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  // Ready is held low while in reset so nothing is taken before release.
  assign in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & alu_is_mul(alu_ctrl);

  always_comb begin
    alu_out  = '0;
    ctrl_bad = 1'b0;
    case (alu_ctrl)
      ALU_AND: alu_out = op_a & op_b;
      ALU_OR:  alu_out = op_a | op_b;
      ALU_ADD: alu_out = op_a + op_b;
      ALU_SUB: alu_out = op_a - op_b;
      ALU_SLT: alu_out = {{(XLEN - 1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_MUL: alu_out = '0;
      default: ctrl_bad = 1'b1;
    endcase
  end

  shift_add_mul #(
    .XLEN(XLEN)
  ) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplicand (op_a),
    .multiplier   (op_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product_lo   (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      if (alu_is_mul(alu_ctrl)) begin
        state_q <= StBusy;
      end else begin
        state_q   <= StDone;
        result_q  <= alu_out;
        zero_q    <= (alu_out == '0);
        illegal_q <= ctrl_bad;
      end
    end else begin
      case (state_q)
        StBusy: begin
          if (mul_done) begin
            state_q   <= StDone;
            result_q  <= mul_product;
            zero_q    <= (mul_product == '0);
            illegal_q <= 1'b0;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Multiplier activity is implied by the BUSY state; kept for observability.
  logic unused_mul_busy;
  assign unused_mul_busy = mul_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from idle; returns at the negedge one cycle after accept.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctrl = 4'b0101;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h1234_5678;
    @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0000;
    op_a      = '0;
    op_b      = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b result=%h zero=%b illegal=%b want 0/0/0/0",
               out_valid, result, zero, illegal);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    send(4'b0010, 32'hFFFF_FFFF, 32'h1);
    total++;
    if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL add_wrap: got valid=%b result=%h zero=%b illegal=%b want 1/00000000/1/0",
               out_valid, result, zero, illegal);
    end
    drain();
    send(4'b0110, 32'd5, 32'd5);
    total++;
    if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL sub_zero: got valid=%b result=%h zero=%b want 1/00000000/1",
               out_valid, result, zero);
    end
    drain();
    send(4'b0110, 32'd3, 32'd5);
    total++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || zero !== 1'b0) begin
      bad++;
      $display("FAIL sub_neg: got valid=%b result=%h zero=%b want 1/fffffffe/0",
               out_valid, result, zero);
    end
    drain();
  endtask

  task automatic test_logic_slt();
    send(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    total++;
    if (result !== 32'h00F0_00F0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL and: got result=%h zero=%b want 00f000f0/0", result, zero);
    end
    drain();
    send(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    total++;
    if (result !== 32'hFFF0_FFF0) begin
      bad++;
      $display("FAIL or: got result=%h want fff0fff0", result);
    end
    drain();
    send(4'b0111, 32'hFFFF_FFFF, 32'h1);
    total++;
    if (result !== 32'h1 || zero !== 1'b0) begin
      bad++;
      $display("FAIL slt_neg_lt_pos: got result=%h zero=%b want 00000001/0", result, zero);
    end
    drain();
    send(4'b0111, 32'h1, 32'hFFFF_FFFF);
    total++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL slt_pos_lt_neg: got result=%h zero=%b want 00000000/1", result, zero);
    end
    drain();
  endtask

  task automatic test_mul();
    int cyc;
    int viol;
    @(negedge clk);
    alu_ctrl = 4'b1000;
    op_a     = 32'h0001_0003;
    op_b     = 32'h0000_0005;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'hFFFF_FFFF;
    cyc  = 0;
    viol = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (!out_valid && in_ready) viol++;
    end while (!out_valid && cyc < 40);
    total++;
    if (cyc !== 33) begin
      bad++;
      $display("FAIL mul_latency: got %0d cycles want 33", cyc);
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL mul_in_ready_busy: in_ready high in %0d busy cycles want 0", viol);
    end
    total++;
    if (result !== 32'h0005_000F || zero !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL mul_value: got result=%h zero=%b illegal=%b want 0005000f/0/0",
               result, zero, illegal);
    end
    drain();
    send(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (out_valid !== 1'b1 || result !== 32'h1) begin
      bad++;
      $display("FAIL mul_all_ones: got valid=%b result=%h want 1/00000001", out_valid, result);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int unstable;
    send(4'b0110, 32'd3, 32'd5);
    unstable = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || in_ready !== 1'b0) unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL backpressure_hold: %0d unstable cycles want 0", unstable);
    end
    @(negedge clk);
    out_ready = 1'b1;
    alu_ctrl  = 4'b0010;
    op_a      = 32'd2;
    op_b      = 32'd2;
    in_valid  = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd4) begin
      bad++;
      $display("FAIL b2b_add: got valid=%b result=%h want 1/00000004", out_valid, result);
    end
    drain();
  endtask

  task automatic test_illegal();
    send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    total++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL illegal_code: got valid=%b illegal=%b result=%h zero=%b want 1/1/0/1",
               out_valid, illegal, result, zero);
    end
    drain();
    send(4'b0010, 32'd1, 32'd1);
    total++;
    if (result !== 32'd2 || illegal !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL after_illegal_add: got result=%h illegal=%b zero=%b want 00000002/0/0",
               result, illegal, zero);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    // Previous op leaves result=2, so a cleared result proves the reset took effect.
    @(negedge clk);
    alu_ctrl = 4'b1000;
    op_a     = 32'd7;
    op_b     = 32'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_mul: got valid=%b result=%h want 0/00000000", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_mul_ready: got %b want 1", in_ready);
    end
    stale = 0;
    out_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    out_ready = 1'b0;
    total++;
    if (stale !== 0) begin
      bad++;
      $display("FAIL reset_mid_mul_stale: out_valid seen %0d cycles want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_slt();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
